// File: rtl/crossbar_pkg.sv
// Shared definitions for the two-master crossbar and its slave-side responders.
package crossbar_pkg;

    // Command encoding carried on the slave port cmd line.
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Data bus width and slave-port word-address width.
    localparam int DATA_W     = 32;
    localparam int SLV_ADDR_W = 31;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } rsp_state_e;

    // Wait-counter load value, clipped to the 4-bit counter range.
    function automatic logic [3:0] wait_load(input int ws);
        if (ws > 15) begin
            return 4'd15;
        end else if (ws < 0) begin
            return 4'd0;
        end
        return 4'(ws);
    endfunction

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-length valid/data shift register carrying read data back to the port.
// Valid bits advance every cycle; a stage's data only loads when a valid word
// enters it, so the final stage holds the last returned word between pulses.
module resp_delay_line
    import crossbar_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic              stage_vld_q  [STAGES];
    logic [DATA_W-1:0] stage_data_q [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // First stage samples the word read from memory in the ack cycle.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_vld_q[gi]  <= 1'b0;
                        stage_data_q[gi] <= '0;
                    end else begin
                        stage_vld_q[gi] <= in_vld;
                        if (in_vld) begin
                            stage_data_q[gi] <= in_data;
                        end
                    end
                end
            end else begin : g_body
                // Later stages take the previous stage's contents each cycle.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_vld_q[gi]  <= 1'b0;
                        stage_data_q[gi] <= '0;
                    end else begin
                        stage_vld_q[gi] <= stage_vld_q[gi-1];
                        if (stage_vld_q[gi-1]) begin
                            stage_data_q[gi] <= stage_data_q[gi-1];
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_vld  = stage_vld_q[STAGES-1];
    assign out_data = stage_data_q[STAGES-1];

endmodule

// File: rtl/slave_mem_responder.sv
// Slave-side memory responder: accepts one read or write at a time, acks it
// after a fixed number of wait states, and returns read data a fixed number
// of cycles after the ack through a delay line.
module slave_mem_responder
    import crossbar_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0,
    parameter int READ_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  cmd,
    input  logic [SLV_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  ack,
    output logic                  resp,
    output logic [DATA_W-1:0]     rdata
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0] WS_LOAD = wait_load(WAIT_STATES);

    rsp_state_e          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_word;

    // Upper address bits alias onto the same words; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[SLV_ADDR_W-1:ADDR_W];

    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state logic: capture in IDLE, count down in WAIT, single-cycle ACK.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cmd_d   = cmd;
                    addr_d  = addr[ADDR_W-1:0];
                    wdata_d = wdata;
                    cnt_d   = WS_LOAD;
                    state_d = (WS_LOAD != 4'd0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                // Inputs are ignored here: the captured request completes even
                // if the master drops req or changes address/data.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and captured-request registers; reset drops any pending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= CMD_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ack   = (state_q == ST_ACK);
    assign wr_en = ack && (cmd_q == CMD_WRITE);
    assign rd_en = ack && (cmd_q == CMD_READ);

    // Word memory write port; reset forces IDLE so a cut ACK never writes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Read address is already registered, and the first delay stage registers
    // the word, so the read stays a synchronous RAM access.
    assign rd_word = mem[addr_q];

    resp_delay_line #(
        .STAGES (READ_LAT)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_en),
        .in_data  (rd_word),
        .out_vld  (resp),
        .out_data (rdata)
    );

endmodule

// File: tb/tb_slave_mem_responder.sv
// Scoreboard bench for slave_mem_responder over four parameter sets.
module tb_slave_mem_responder;

    localparam int NCFG = 4;
    localparam int CFG_AW [NCFG] = '{10, 6, 10, 8};
    localparam int CFG_WS [NCFG] = '{0, 3, 0, 2};
    localparam int CFG_RL [NCFG] = '{1, 8, 4, 3};

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk;
    int   n_checks;
    int   n_pass;
    wire [NCFG-1:0] done_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int AW    = CFG_AW[gi];
            localparam int WS    = CFG_WS[gi];
            localparam int RL    = CFG_RL[gi];
            localparam int DEPTH = 2 ** AW;

            logic        rst_l;
            logic        req_l;
            logic        cmd_l;
            logic [30:0] addr_l;
            logic [31:0] wdata_l;
            logic        ack_w;
            logic        resp_w;
            logic [31:0] rdata_w;
            logic        done_l;

            int          cyc;
            int          ack_q [$];
            exp_t        resp_q [$];
            logic [31:0] mm [int];
            logic [31:0] hold;

            assign done_w[gi] = done_l;

            slave_mem_responder #(
                .ADDR_W      (AW),
                .WAIT_STATES (WS),
                .READ_LAT    (RL)
            ) dut (
                .clk   (clk),
                .rst   (rst_l),
                .req   (req_l),
                .cmd   (cmd_l),
                .addr  (addr_l),
                .wdata (wdata_l),
                .ack   (ack_w),
                .resp  (resp_w),
                .rdata (rdata_w)
            );

            // One request: expectations come from the memory model, in order.
            task automatic do_txn(input bit c, input logic [30:0] a,
                                  input logic [31:0] d, input bit drop);
                int   t;
                int   idx;
                exp_t e;
                @(negedge clk);
                t       = cyc;
                req_l   = 1'b1;
                cmd_l   = c;
                addr_l  = a;
                wdata_l = d;
                idx     = int'(a % 31'(DEPTH));
                ack_q.push_back(t + 1 + WS);
                if (c) begin
                    mm[idx] = d;
                end else begin
                    e.cyc  = t + 1 + WS + RL;
                    e.data = mm[idx];
                    resp_q.push_back(e);
                end
                $display("cfg%0d txn %s addr=%h data=%h drop=%0d ack@%0d", gi,
                         c ? "WR" : "RD", a, c ? d : mm[idx], drop, t + 1 + WS);
                @(negedge clk);
                cmd_l   = 1'($urandom);
                addr_l  = 31'($urandom);
                wdata_l = $urandom;
                if (drop) req_l = 1'b0;
                repeat (WS) @(negedge clk);
                req_l = 1'b0;
            endtask

            // Output monitor: every cycle, ack/resp must match the scoreboard.
            initial begin
                cyc  = 0;
                hold = '0;
                forever begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (rst_l) begin
                        ack_q.delete();
                        resp_q.delete();
                        hold = '0;
                        chk(ack_w === 1'b0, $sformatf("cfg%0d reset ack", gi), 32'(ack_w), 0);
                        chk(resp_w === 1'b0, $sformatf("cfg%0d reset resp", gi), 32'(resp_w), 0);
                        chk(rdata_w === 32'h0, $sformatf("cfg%0d reset rdata", gi), rdata_w, 0);
                    end else begin
                        if (ack_q.size() > 0 && ack_q[0] == cyc) begin
                            chk(ack_w === 1'b1, $sformatf("cfg%0d ack c%0d", gi, cyc), 32'(ack_w), 1);
                            void'(ack_q.pop_front());
                        end else begin
                            chk(ack_w === 1'b0, $sformatf("cfg%0d spurious ack c%0d", gi, cyc), 32'(ack_w), 0);
                        end
                        if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
                            chk(resp_w === 1'b1, $sformatf("cfg%0d resp c%0d", gi, cyc), 32'(resp_w), 1);
                            chk(rdata_w === resp_q[0].data, $sformatf("cfg%0d rdata c%0d", gi, cyc),
                                rdata_w, resp_q[0].data);
                            hold = resp_q[0].data;
                            void'(resp_q.pop_front());
                        end else begin
                            chk(resp_w === 1'b0, $sformatf("cfg%0d spurious resp c%0d", gi, cyc), 32'(resp_w), 0);
                            chk(rdata_w === hold, $sformatf("cfg%0d rdata hold c%0d", gi, cyc), rdata_w, hold);
                        end
                    end
                end
            end

            // Stimulus: directed cases for this parameter set, then random traffic.
            initial begin : stim
                int          low;
                logic [30:0] a;
                bit          c;
                bit          drop;
                int          gap;
                rst_l   = 1'b1;
                req_l   = 1'b0;
                cmd_l   = 1'b0;
                addr_l  = '0;
                wdata_l = '0;
                done_l  = 1'b0;
                repeat (3) @(negedge clk);
                rst_l = 1'b0;

                if (gi == 0) begin
                    do_txn(1'b1, 31'd5, 32'hDEADBEEF, 1'b0);
                    do_txn(1'b0, 31'd5, 32'h0, 1'b0);
                    do_txn(1'b1, 31'h400, 32'h000000A5, 1'b0);
                    do_txn(1'b0, 31'd0, 32'h0, 1'b0);
                end else if (gi == 1) begin
                    do_txn(1'b1, 31'd9, 32'h13579BDF, 1'b0);
                    do_txn(1'b0, 31'd9, 32'h0, 1'b0);
                end else if (gi == 2) begin
                    do_txn(1'b1, 31'd1, 32'h11, 1'b0);
                    do_txn(1'b1, 31'd2, 32'h22, 1'b0);
                    do_txn(1'b1, 31'd3, 32'h33, 1'b0);
                    do_txn(1'b0, 31'd1, 32'h0, 1'b0);
                    do_txn(1'b0, 31'd2, 32'h0, 1'b0);
                    do_txn(1'b0, 31'd3, 32'h0, 1'b0);
                    repeat (6) @(negedge clk);
                    // Read in flight, then reset two cycles after its ack.
                    do_txn(1'b0, 31'd2, 32'h0, 1'b0);
                    repeat (2) @(negedge clk);
                    rst_l = 1'b1;
                    repeat (2) @(negedge clk);
                    rst_l = 1'b0;
                    repeat (8) @(negedge clk);
                    do_txn(1'b0, 31'd3, 32'h0, 1'b0);
                end else begin
                    do_txn(1'b1, 31'd4, 32'hCAFEF00D, 1'b1);
                    do_txn(1'b0, 31'd4, 32'h0, 1'b0);
                end

                for (int i = 0; i < 40; i++) begin
                    low  = int'($urandom_range(0, 7));
                    a    = (31'($urandom) & ~31'(DEPTH - 1)) | 31'(low);
                    c    = mm.exists(low) ? 1'($urandom_range(0, 1)) : 1'b1;
                    drop = (WS > 0) && ($urandom_range(0, 7) == 0);
                    do_txn(c, a, $urandom, drop);
                    gap = int'($urandom_range(0, 2));
                    repeat (gap) @(negedge clk);
                end
                repeat (RL + 4) @(negedge clk);
                chk(resp_q.size() == 0, $sformatf("cfg%0d pending resp", gi), 32'(resp_q.size()), 0);
                chk(ack_q.size() == 0, $sformatf("cfg%0d pending ack", gi), 32'(ack_q.size()), 0);
                done_l = 1'b1;
            end
        end
    endgenerate

    initial begin
        int k;
        n_checks = 0;
        n_pass   = 0;
        k        = 0;
        while (done_w != {NCFG{1'b1}} && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk(done_w == {NCFG{1'b1}}, "completion", 32'(done_w), 32'((1 << NCFG) - 1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
